// File: rtl/hs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hs_pkg
//  Description : Shared types for the valid/ready pattern source family.
//                hs_mode_e      - inter-beat spacing mode selector
//                hs_src_state_e - pattern source sequencing states
//  Revision    : 1.0 - initial release
// ============================================================================
package hs_pkg;

    typedef enum logic [1:0] {
        MODE_B2B  = 2'd0,
        MODE_ALT  = 2'd1,
        MODE_GAP  = 2'd2,
        MODE_RSVD = 2'd3
    } hs_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        FIN  = 2'd3
    } hs_src_state_e;

endpackage : hs_pkg
`default_nettype wire

// File: rtl/hs_gap_timer.sv
`default_nettype none
// ============================================================================
//  Module      : hs_gap_timer
//  Description : Loadable down-counter that times an idle gap.
//                Loading len=G makes 'expired' assert in the G-th cycle after
//                the load edge, so a consumer that leaves its wait state on
//                'expired' spends exactly G cycles waiting.
//  Ports       : clk     - clock, rising edge
//                rst     - synchronous active-high reset
//                load    - load 'len' into the counter
//                len     - gap length in cycles (GAP_W bits)
//                expired - current cycle is the last one of the gap
//  Revision    : 1.0 - initial release
// ============================================================================
module hs_gap_timer #(
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [GAP_W-1:0] len,
    output logic             expired
);

    logic [GAP_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= len;
        end else if (r_count != '0) begin
            r_count <= r_count - GAP_W'(1);
        end
    end

    // Count G..1 across the gap; the cycle holding 1 is the last idle cycle.
    assign expired = (r_count <= GAP_W'(1));

endmodule : hs_gap_timer
`default_nettype wire

// File: rtl/hs_pattern_source.sv
`default_nettype none
// ============================================================================
//  Module      : hs_pattern_source
//  Description : Valid/ready traffic source. On 'start' it emits beat_count
//                beats of incrementing data starting at data_base, with
//                back-to-back, alternating or fixed-gap spacing, honouring
//                downstream backpressure.
//  Ports       : clk, rst         - clock / synchronous active-high reset
//                start            - begin a sequence (ignored while busy)
//                mode, gap        - spacing mode and gap length (mode 2)
//                beat_count       - number of beats to send
//                data_base        - data of the first beat
//                ready_down_in    - downstream ready
//                data_out         - registered beat data
//                valid_down_out   - registered beat valid
//                busy             - sequence in progress
//                done             - one-cycle pulse after the final handshake
//                beats_sent       - handshakes completed this/last sequence
//  Revision    : 1.0 - initial release
// ============================================================================
module hs_pattern_source
    import hs_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int GAP_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [GAP_W-1:0] gap,
    input  logic [CNT_W-1:0] beat_count,
    input  logic [WIDTH-1:0] data_base,
    input  logic             ready_down_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_down_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] beats_sent
);

    hs_src_state_e    r_state;
    hs_src_state_e    w_state_nxt;

    // Configuration latched on the accepted start edge.
    hs_mode_e         r_cfg_mode;
    logic [GAP_W-1:0] r_cfg_gap;
    logic [CNT_W-1:0] r_cfg_count;

    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_beats_sent;

    logic             w_fire;
    logic [CNT_W-1:0] w_beats_inc;
    logic             w_last;
    logic [GAP_W-1:0] w_eff_gap;
    logic             w_gap_load;
    logic             w_gap_expired;

    assign w_fire      = r_valid && ready_down_in;
    assign w_beats_inc = r_beats_sent + CNT_W'(1);
    assign w_last      = (w_beats_inc == r_cfg_count);

    // Idle cycles inserted between beats; the reserved mode behaves as B2B.
    always_comb begin
        w_eff_gap = '0;
        case (r_cfg_mode)
            MODE_ALT: w_eff_gap = GAP_W'(1);
            MODE_GAP: w_eff_gap = r_cfg_gap;
            default:  w_eff_gap = '0;
        endcase
    end

    assign w_gap_load = (r_state == SEND) && w_fire && !w_last && (w_eff_gap != '0);

    hs_gap_timer #(
        .GAP_W (GAP_W)
    ) u_gap_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (w_gap_load),
        .len     (w_eff_gap),
        .expired (w_gap_expired)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = (beat_count == '0) ? FIN : SEND;
                end
            end
            SEND: begin
                if (w_fire) begin
                    if (w_last) begin
                        w_state_nxt = FIN;
                    end else if (w_eff_gap != '0) begin
                        w_state_nxt = GAP;
                    end
                end
            end
            GAP: begin
                if (w_gap_expired) begin
                    w_state_nxt = SEND;
                end
            end
            FIN: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Status outputs are registered copies of the next-state decode, so they
    // line up with r_state without any output decoding after the flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cfg_mode   <= MODE_B2B;
            r_cfg_gap    <= '0;
            r_cfg_count  <= '0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_beats_sent <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= (w_state_nxt == SEND);
            r_done  <= (w_state_nxt == FIN);
            r_busy  <= (w_state_nxt != IDLE);
            if ((r_state == IDLE) && start) begin
                r_cfg_mode   <= hs_mode_e'(mode);
                r_cfg_gap    <= gap;
                r_cfg_count  <= beat_count;
                r_data       <= data_base;
                r_beats_sent <= '0;
            end else if (w_fire) begin
                r_data       <= r_data + WIDTH'(1);
                r_beats_sent <= w_beats_inc;
            end
        end
    end

    assign data_out       = r_data;
    assign valid_down_out = r_valid;
    assign busy           = r_busy;
    assign done           = r_done;
    assign beats_sent     = r_beats_sent;

endmodule : hs_pattern_source
`default_nettype wire
